// File: rtl/squarer_iter.sv
// squarer_iter: sequential squarer, p = a*a, one shift-add step per clock.
//
// The operand is first reduced to its magnitude. For a signed operand that
// means negating it when the sign bit is set. The magnitude is then squared by
// conditional shift-and-add over its WIDTH bits. The result is always
// non-negative, so signed and unsigned operands share the same datapath.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand presented
//   in_ready   block can accept an operand (high only in IDLE)
//   a          WIDTH-bit operand
//   is_signed  1 = a is two's complement; sampled together with a
//   out_valid  result available (high only in DONE)
//   out_ready  consumer accepts the result
//   p          2*WIDTH-bit square; holds its value until the next result

module squarer_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mag_q, mag_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    p_q, p_d;

  // Operand magnitude. The most negative value negates to itself. Read as an
  // unsigned WIDTH-bit number, that value is exactly 2^(WIDTH-1), which is the
  // correct magnitude.
  logic             neg_in;
  logic [WIDTH-1:0] a_mag;

  // Partial-product datapath for the current bit step.
  logic [PW-1:0] mag_ext;
  logic [PW-1:0] partial;
  logic [PW-1:0] acc_sum;
  logic          last_step;

  assign neg_in  = is_signed & a[WIDTH-1];
  assign a_mag   = neg_in ? -a : a;

  assign mag_ext   = {{WIDTH{1'b0}}, mag_q};
  assign partial   = mag_q[cnt_q] ? (mag_ext << cnt_q) : '0;
  assign acc_sum   = acc_q + partial;
  assign last_step = (cnt_q == LastCnt);

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mag_d   = a_mag;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end

      StCalc: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          // The final partial product goes straight into the result register.
          p_d     = acc_sum;
          state_d = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs are pure state decodes, so reset drives them at once.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign p = p_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_squarer_iter.sv
// Directed bench for squarer_iter. It drives a WIDTH=8 instance through the
// latency, signed/unsigned, backpressure and reset-abort cases. It sweeps a
// WIDTH=4 instance exhaustively in both modes.
module tb_squarer_iter;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8;
  logic [7:0]  a8;
  logic [15:0] p8;

  logic        in_valid4, in_ready4, is_signed4, out_valid4, out_ready4;
  logic [3:0]  a4;
  logic [7:0]  p4;

  int n_checks;
  int n_fail;

  squarer_iter #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .is_signed (is_signed8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .p         (p8)
  );

  squarer_iter #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .is_signed (is_signed4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .p         (p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one WIDTH=8 operand and follows it through CALC into DONE.
  // It checks the latency and the result. The block is left waiting in DONE.
  task automatic run8(input string tag, input logic [7:0] av, input logic sv,
                      input logic [15:0] exp);
    int   guard;
    logic early;
    logic busy_bad;
    guard = 0;
    while (!in_ready8 && guard < 40) begin
      step();
      guard++;
    end
    chk({tag, "_ready_before"}, 32'(in_ready8), 32'd1);
    a8         = av;
    is_signed8 = sv;
    in_valid8  = 1'b1;
    step();  // accept edge k
    in_valid8  = 1'b0;
    chk({tag, "_in_ready_calc"}, 32'(in_ready8), 32'd0);
    early    = 1'b0;
    busy_bad = 1'b0;
    repeat (7) begin
      step();
      if (out_valid8) early = 1'b1;
      if (in_ready8) busy_bad = 1'b1;
    end
    chk({tag, "_no_early_valid"}, 32'(early), 32'd0);
    chk({tag, "_busy_in_calc"}, 32'(busy_bad), 32'd0);
    step();  // edge k+8
    chk({tag, "_out_valid"}, 32'(out_valid8), 32'd1);
    chk({tag, "_p"}, 32'(p8), 32'(exp));
    chk({tag, "_in_ready_done"}, 32'(in_ready8), 32'd0);
  endtask

  task automatic consume8(input string tag);
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid8), 32'd0);
    chk({tag, "_back_idle"}, 32'(in_ready8), 32'd1);
  endtask

  task automatic run4(input logic [3:0] av, input logic sv);
    int          guard;
    int          mag;
    logic [7:0]  exp;
    mag = int'(av);
    if (sv && av[3]) mag = 16 - int'(av);
    exp = 8'(mag * mag);
    a4         = av;
    is_signed4 = sv;
    in_valid4  = 1'b1;
    step();
    in_valid4  = 1'b0;
    guard = 0;
    while (!out_valid4 && guard < 20) begin
      step();
      guard++;
    end
    chk($sformatf("w4_valid_s%0d_a%0d", sv, av), 32'(out_valid4), 32'd1);
    chk($sformatf("w4_p_s%0d_a%0d", sv, av), 32'(p4), 32'(exp));
    chk($sformatf("w4_p1_s%0d_a%0d", sv, av), 32'(p4[1]), 32'd0);
    chk($sformatf("w4_p0_s%0d_a%0d", sv, av), 32'(p4[0]), 32'(av[0]));
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
  endtask

  initial begin
    logic [15:0] p_hold;
    logic        stable;
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid8  = 1'b0;
    a8         = '0;
    is_signed8 = 1'b0;
    out_ready8 = 1'b0;
    in_valid4  = 1'b0;
    a4         = '0;
    is_signed4 = 1'b0;
    out_ready4 = 1'b0;

    #1;
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_p", 32'(p8), 32'd0);
    #11;
    rst_n = 1'b1;
    step();

    run8("u15", 8'd15, 1'b0, 16'd225);
    consume8("u15");
    run8("u255", 8'd255, 1'b0, 16'd65025);
    consume8("u255");
    run8("u0", 8'd0, 1'b0, 16'd0);
    consume8("u0");
    run8("s80", 8'h80, 1'b1, 16'd16384);
    consume8("s80");
    run8("sFF", 8'hFF, 1'b1, 16'd1);
    consume8("sFF");
    run8("uFF", 8'hFF, 1'b0, 16'd65025);
    consume8("uFF");

    // Backpressure: signed 0x9C is -100, so its square is 10000.
    run8("bp", 8'h9C, 1'b1, 16'd10000);
    p_hold = p8;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid8 = ~in_valid8;
      a8        = 8'(8'd3 + 8'(i));
      step();
      if (!out_valid8 || p8 !== p_hold || in_ready8) stable = 1'b0;
    end
    in_valid8 = 1'b0;
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_p_hold", 32'(p8), 32'd10000);
    consume8("bp");
    chk("bp_p_kept_idle", 32'(p8), 32'd10000);

    // Abort in the middle of CALC; p must clear without waiting for an edge.
    a8         = 8'd7;
    is_signed8 = 1'b0;
    in_valid8  = 1'b1;
    step();
    in_valid8  = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid8), 32'd0);
    chk("abort_in_ready", 32'(in_ready8), 32'd1);
    chk("abort_p", 32'(p8), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    run8("u9", 8'd9, 1'b0, 16'd81);
    consume8("u9");

    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 16; v++) begin
        run4(4'(v), 1'(s));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // A hung run becomes a failure instead of an endless simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/squarer_iter.md
Name: squarer_iter

Overview:
- Parametrised sequential squarer; successor to the fixed 4-bit combinational squarer.
- Computes p = a*a for a WIDTH-bit operand using one shift-add step per clock.
- Supports unsigned and two's-complement signed operands, selected per transaction.
- Sits in the arithmetic datapath behind valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 8, operand width in bits (2..32).
- CW, $clog2(WIDTH), bit-step counter width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand.
- a  input  WIDTH  operand.
- is_signed  input  1  1 = a is two's complement; sampled with a.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- p  output  2*WIDTH  square of a, always non-negative.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - On rst_n low, immediately: state=IDLE, in_ready=1, out_valid=0, p=0, accumulator=0, counter=0.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, load mag = (is_signed && a[WIDTH-1]) ? -a : a, zero-extended to WIDTH bits.
  - On the same edge, clear acc and cnt, then go to CALC.
- CALC (in_ready=0):
  - Each edge: if mag[cnt]=1 then acc <= acc + (mag << cnt). Then cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1, apply the final add, then p <= final acc and go to DONE.
- DONE:
  - out_valid=1; p is held stable.
  - On an edge with out_ready=1, set out_valid=0 and go to IDLE.
  - Without out_ready, hold p and out_valid indefinitely (backpressure).
- Latency: handshake accepted at edge k; out_valid=1 after edge k+WIDTH. Throughput is one result per WIDTH+2 cycles minimum.
- Width rules:
  - acc is 2*WIDTH bits; no overflow is possible.
  - Signed magnitude is at most 2^(WIDTH-1); -2^(WIDTH-1) negates to 2^(WIDTH-1), which is correct as an unsigned WIDTH-bit value.
  - p[1] is always 0. p[0] always equals a[0].
- in_valid while not in IDLE is ignored; a and is_signed are not re-sampled.
- p keeps its last value in IDLE and CALC until the next DONE load.
- Reset asserted mid-CALC or mid-DONE aborts the transaction; no partial result is emitted.

Test Plan:
- WIDTH=8, is_signed=0, a=15 -> out_valid exactly 8 cycles after accept, p=225; in_ready=0 throughout CALC/DONE.
- WIDTH=8, unsigned a=255 -> p=65025. Then a=0 -> p=0, with out_valid still asserted after 8 cycles.
- WIDTH=8, is_signed=1: a=0x80 -> p=16384; a=0xFF -> p=1. Same bits with is_signed=0: a=0xFF -> p=65025.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> p and out_valid stable; toggling in_valid meanwhile is ignored; out_ready=1 -> IDLE next edge.
- Reset mid-CALC (cycle 3 of 8) -> out_valid=0, in_ready=1, p=0 immediately. Next transaction a=9 -> p=81.
- WIDTH=4 exhaustive: all 16 operands in both modes checked against a*a; bits p[1]=0 and p[0]=a[0] asserted on every result.
